// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// parameter defaults and a one-hot to index helper.
package uart_pkg;

    localparam int          N_CLIENTS_DEFAULT    = 3;
    localparam logic [15:0] IDLE_TIMEOUT_DEFAULT = 16'd50000;

    // Client index width; two bits cover the largest supported arbiter (4 clients).
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } arb_state_t;

    // Convert a one-hot (or zero) vector of up to four clients to an index.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin next-owner search: first requester at or above rr_ptr,
// wrapping around, returned as a one-hot pick plus a valid flag.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_CLIENTS = N_CLIENTS_DEFAULT
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 valid,
    output logic [N_CLIENTS-1:0] pick
);

    logic [2*N_CLIENTS-1:0] req_dbl;
    logic [2*N_CLIENTS-1:0] pick_dbl;
    logic [N_CLIENTS-1:0]   first;

    // Rotate req so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        valid    = 1'b0;
        first    = '0;
        req_dbl  = {req, req} >> rr_ptr;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (!valid && req_dbl[k]) begin
                first[k] = 1'b1;
                valid    = 1'b1;
            end
        end
        pick_dbl = {{N_CLIENTS{1'b0}}, first} << rr_ptr;
        pick     = pick_dbl[N_CLIENTS-1:0] | pick_dbl[2*N_CLIENTS-1:N_CLIENTS];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_CLIENTS requesters. A granted client
// drives bytes through as if it owned the UART; everyone else sees busy.
// Ownership ends on req drop or idle timeout, then the UART is drained.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          N_CLIENTS    = N_CLIENTS_DEFAULT,
    parameter logic [15:0] IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CLIENTS-1:0]   req,
    output logic [N_CLIENTS-1:0]   gnt,
    input  logic [8*N_CLIENTS-1:0] c_tx_data,
    input  logic [N_CLIENTS-1:0]   c_tx_start,
    output logic [N_CLIENTS-1:0]   c_tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   timeout_err
);

    arb_state_t           state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     rr_ptr;
    logic [15:0]          idle_cnt;

    logic                 pick_valid;
    logic [N_CLIENTS-1:0] pick;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     next_ptr;

    logic                 owner_start;
    logic                 owner_req;
    logic [7:0]           owner_data;

    rr_pick #(
        .N_CLIENTS (N_CLIENTS)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .pick   (pick)
    );

    assign pick_idx = onehot_to_idx(4'(pick));
    assign next_ptr = (owner == IDX_W'(N_CLIENTS - 1)) ? '0 : owner + IDX_W'(1);

    // Owner view: select the granted client's inputs and fan busy out to all clients.
    always_comb begin
        owner_start = |(c_tx_start & gnt);
        owner_req   = |(req & gnt);
        owner_data  = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (gnt[i]) owner_data = c_tx_data[8*i +: 8];
            // The pending tx_start keeps busy high until the UART raises its own busy.
            c_tx_busy[i] = gnt[i] ? (tx_busy | tx_start) : 1'b1;
        end
    end

    // Arbitration FSM with registered grant, forwarded start/data and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gnt         <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            idle_cnt    <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        gnt      <= pick;
                        owner    <= pick_idx;
                        idle_cnt <= '0;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Gating on tx_start keeps start pulses at least one cycle apart.
                    if (owner_start && !tx_start) begin
                        tx_start <= 1'b1;
                        tx_data  <= owner_data;
                    end
                    if (!tx_busy && !owner_start && !tx_start) begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end else begin
                        idle_cnt <= '0;
                    end
                    // A req drop wins over a simultaneous timeout and raises no error.
                    if (!owner_req) begin
                        gnt   <= '0;
                        state <= S_DRAIN;
                    end else if (idle_cnt == IDLE_TIMEOUT - 16'd1) begin
                        gnt         <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Exit only to S_IDLE, so owners are always separated by an idle cycle.
                    if (!tx_busy && !tx_start) begin
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_CLIENTS, default 3, is the number of requesters sharing the UART transmitter (2..4).
REQ-002 Parameter IDLE_TIMEOUT, default 16'd50000, is the number of cycles a granted client may stay inactive before its grant is revoked.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_CLIENTS  per-client message request, held high for a whole message.
REQ-006 gnt  output  N_CLIENTS  one-hot grant; the client owns the UART while its bit is high.
REQ-007 c_tx_data  input  8*N_CLIENTS  per-client byte; client i uses bits [8i+7:8i].
REQ-008 c_tx_start  input  N_CLIENTS  per-client single-cycle byte start pulse.
REQ-009 c_tx_busy  output  N_CLIENTS  per-client busy view.
REQ-010 tx_data  output  8  byte to the UART transmitter.
REQ-011 tx_start  output  1  start pulse to the UART transmitter.
REQ-012 tx_busy  input  1  UART transmitter busy.
REQ-013 timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 The arbiter SHALL have three states: S_IDLE, S_GRANT and S_DRAIN.
REQ-015 In S_IDLE with any req bit high, the arbiter SHALL grant the first requesting client at or after rr_ptr, searching upward with wrap-around.
REQ-016 On a grant, the arbiter SHALL set gnt one cycle after the decision, enter S_GRANT and clear the idle counter.
REQ-017 In S_GRANT, a c_tx_start pulse from the owner SHALL appear as tx_start exactly one cycle later, with tx_data registered from that owner's byte in the same edge.
REQ-018 tx_start SHALL never be high for two consecutive cycles.
REQ-019 c_tx_start from a non-owner SHALL be ignored and SHALL NOT be queued.
REQ-020 The owner's c_tx_busy SHALL be tx_busy OR the pending tx_start register, so a client that waits for busy-high then busy-low works unchanged.
REQ-021 Every non-owner's c_tx_busy SHALL be held at 1.
REQ-022 A c_tx_start from the owner while tx_busy is 1 SHALL be forwarded unchanged; the UART defines the result.
REQ-023 In S_GRANT, the idle counter SHALL increment every cycle that tx_busy, the owner's c_tx_start and tx_start are all 0, and SHALL clear otherwise.
REQ-024 When the owner's req goes low in S_GRANT, the arbiter SHALL drop gnt on the next edge and enter S_DRAIN.
REQ-025 When the idle counter reaches IDLE_TIMEOUT-1, the arbiter SHALL drop gnt on the next edge, pulse timeout_err for one cycle and enter S_DRAIN.
REQ-026 If req-low and timeout occur in the same cycle, the arbiter SHALL take the req-low path with no timeout_err.
REQ-027 In S_DRAIN, the arbiter SHALL wait until tx_busy is 0 and tx_start is 0, then set rr_ptr to owner+1 (mod N_CLIENTS) and enter S_IDLE.
REQ-028 A new grant SHALL never be issued in the same cycle that S_DRAIN exits, giving a minimum of one S_IDLE cycle between owners.
REQ-029 A client whose grant was revoked but still holds req SHALL be eligible again in round-robin order.
REQ-030 If the owner's req is still high at drain exit, that client SHALL be treated as a new request.
REQ-031 In S_GRANT, req changes on non-owner bits SHALL have no effect.
REQ-032 gnt SHALL be one-hot or zero at all times.

Reset
REQ-033 While rst_n is low, the block SHALL hold state=S_IDLE, gnt=0, tx_start=0, tx_data=8'h00, timeout_err=0, rr_ptr=0 and idle counter=0.
REQ-034 All c_tx_busy bits SHALL be 1 during reset.
REQ-035 A reset mid-byte SHALL abandon ownership immediately, with no drain.
REQ-036 After reset release, the first grant SHALL go to the lowest-index requester.

Structure
REQ-037 State encodings and the N_CLIENTS and IDLE_TIMEOUT defaults SHALL live in the shared uart_pkg package.
REQ-038 The round-robin next-owner search SHALL be one combinational sub-module, rr_pick (inputs req and rr_ptr; outputs valid and one-hot pick).
REQ-039 The rest of the block SHALL be a single clocked process plus a combinational busy fan-out.

Verification
REQ-040 A bench SHALL cover: req=3'b001, client 0 pulses start with 8'h41 -> gnt=001 and tx_start one cycle after the pulse with tx_data=8'h41; clients 1 and 2 see busy=1.
REQ-041 A bench SHALL cover: req=3'b111 from reset, each client sends 2 bytes then drops req -> grant order 0,1,2,0 with at least one S_IDLE cycle and tx_busy=0 between owners.
REQ-042 A bench SHALL cover: client 1 pulses c_tx_start while client 0 owns -> no tx_start, and client 1's data never appears on tx_data.
REQ-043 A bench SHALL cover: IDLE_TIMEOUT=20, owner 2 holds req without sending -> gnt drops after 20 idle cycles, a single timeout_err pulse, and client 0 is granted next when requesting.
REQ-044 A bench SHALL cover: owner drops req while tx_busy=1 -> S_DRAIN held until tx_busy=0, with no grant before then.
REQ-045 A bench SHALL cover: rst_n asserted mid-byte -> gnt=0, tx_start=0 and c_tx_busy=all 1s immediately, and the first grant after release goes to the lowest requester.
